if_fetch: RTL

Instruction-fetch stage of the Mips52Ins pipeline. Holds the architectural PC, issues one instruction-memory read per PC using a grant/response handshake, and loads the fetched word into the IF/ID pipeline register. The current PC goes to the next-PC selector; the selected next PC comes back on `npc` and is loaded when the current fetch retires. Stall and flush come from the hazard/branch logic.

---
 rtl/if_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch : Mips52Ins instruction fetch (PC, imem handshake, IF/ID register)
// Rev 1.0
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_ins,
  output logic        if_id_valid,
  output logic        if_id_adel
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_ins_q, if_id_ins_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        if_id_adel_q, if_id_adel_d;

  logic        retire;
  logic [31:0] ret_word;
  logic        ret_adel;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_ins_d   = if_id_ins_q;
    if_id_valid_d = if_id_valid_q;
    if_id_adel_d  = if_id_adel_q;
    retire        = 1'b0;
    ret_word      = 32'h0;
    ret_adel      = 1'b0;
    imem_req      = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (misaligned) begin
          // Misaligned PC never reaches memory; it retires as an exception slot.
          if (!stall) begin
            retire   = 1'b1;
            ret_adel = 1'b1;
          end
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (!stall) begin
            retire   = 1'b1;
            ret_word = imem_rdata;
          end else begin
            buf_d   = imem_rdata;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!stall) begin
          retire   = 1'b1;
          ret_word = buf_q;
        end else if (flush) begin
          pc_d    = npc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (retire) begin
      pc_d    = npc;
      state_d = ST_REQ;
    end

    // Flush beats retire: the PC still advances but the slot is squashed.
    if (flush) begin
      if_id_valid_d = 1'b0;
      if_id_adel_d  = 1'b0;
    end else if (retire) begin
      if_id_pc_d    = pc_q;
      if_id_ins_d   = ret_word;
      if_id_valid_d = 1'b1;
      if_id_adel_d  = ret_adel;
    end else if (!stall) begin
      if_id_valid_d = 1'b0;
      if_id_adel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      buf_q         <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_ins_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_adel_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_ins_q   <= if_id_ins_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_adel_q  <= if_id_adel_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_ins   = if_id_ins_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_adel  = if_id_adel_q;

endmodule
`default_nettype wire
